// File: rtl/greth_init_pkg.sv
// Types and default command table for the GRETH bring-up sequencer.
package greth_init_pkg;

  localparam int CMD_ADDR_W  = 8;
  localparam int CMD_DATA_W  = 32;
  localparam int TABLE_DEPTH = 8;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_POLL  = 2'd1,
    OP_DELAY = 2'd2,
    OP_END   = 2'd3
  } op_e;

  typedef struct packed {
    op_e                   op;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
    logic [CMD_DATA_W-1:0] mask;
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETUP,
    ST_ACCESS,
    ST_POLL_WAIT,
    ST_DELAY,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam cmd_t GRETH_INIT_TABLE [0:TABLE_DEPTH-1] = '{
    '{op: OP_WRITE, addr: 8'h04, data: 32'h0000_0A0B, mask: 32'h0000_0000},
    '{op: OP_WRITE, addr: 8'h08, data: 32'h0C0D_0E0F, mask: 32'h0000_0000},
    '{op: OP_POLL,  addr: 8'h10, data: 32'h0000_0000, mask: 32'h0000_0008},
    '{op: OP_WRITE, addr: 8'h14, data: 32'h4000_0000, mask: 32'h0000_0000},
    '{op: OP_WRITE, addr: 8'h18, data: 32'h4000_0400, mask: 32'h0000_0000},
    '{op: OP_DELAY, addr: 8'h00, data: 32'h0000_0010, mask: 32'h0000_0000},
    '{op: OP_WRITE, addr: 8'h00, data: 32'h0000_0003, mask: 32'h0000_0000},
    '{op: OP_END,   addr: 8'h00, data: 32'h0000_0000, mask: 32'h0000_0000}
  };

  function automatic logic poll_hit(input logic [CMD_DATA_W-1:0] rd, input cmd_t cmd);
    return (rd & cmd.mask) == cmd.data;
  endfunction

endpackage

// File: rtl/greth_init_rom.sv
// Combinational command lookup; indices past the table read as END.
module greth_init_rom
  import greth_init_pkg::*;
#(
  parameter int IDX_W = 3
)(
  input  logic [IDX_W-1:0] i_idx,
  output cmd_t             o_cmd
);

  always_comb begin
    o_cmd = '{op: OP_END, addr: '0, data: '0, mask: '0};
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      if (int'(i_idx) == i) o_cmd = GRETH_INIT_TABLE[i];
    end
  end

endmodule

// File: rtl/greth_init_sequencer.sv
// APB master that walks the GRETH bring-up command table after reset.
//   state     | meaning
//   IDLE      | waiting for start after reset
//   FETCH     | latch command at idx and dispatch on its op
//   SETUP     | APB setup phase (psel=1, penable=0)
//   ACCESS    | APB access phase, held until pready
//   POLL_WAIT | idle gap before re-reading a POLL register
//   DELAY     | fixed wait from command data[15:0]
//   DONE      | sequence completed, done held
//   ERROR     | slave error or poll timeout, error held
module greth_init_sequencer
  import greth_init_pkg::*;
#(
  parameter  int ADDR_W       = 8,
  parameter  int DATA_W       = 32,
  parameter  int NUM_CMDS     = 8,
  parameter  int POLL_TIMEOUT = 1024,
  parameter  int POLL_GAP     = 4,
  localparam int IDX_W        = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [IDX_W-1:0]  err_idx
);

  localparam int PC_W  = $clog2(POLL_TIMEOUT + 1);
  localparam int CNT_W = (PC_W > 16) ? PC_W : 16;
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'((POLL_GAP > 1) ? POLL_GAP - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CMDS - 1);
  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_TIMEOUT - 1);

  state_e           r_state, w_state_nxt;
  cmd_t             r_cmd, w_cmd;
  logic [IDX_W-1:0] r_idx, r_err_idx;
  logic [CNT_W-1:0] r_cnt, w_dly_load;
  logic [GAP_W-1:0] r_gap;
  logic [15:0]      w_dly;
  logic             w_last, w_hit, w_poll_more, w_poll_miss, w_idle_like;

  greth_init_rom #(.IDX_W(IDX_W)) u_rom (
    .i_idx (r_idx),
    .o_cmd (w_cmd)
  );

  assign w_last      = (r_idx == IDX_LAST);
  assign w_hit       = poll_hit(CMD_DATA_W'(prdata), r_cmd);
  assign w_poll_miss = (r_cmd.op == OP_POLL) && !w_hit;
  // r_cnt holds reads already missed, so one more read is allowed below TIMEOUT-1
  assign w_poll_more = (r_cnt < POLL_LAST);
  assign w_dly       = w_cmd.data[15:0];
  assign w_dly_load  = (w_dly == 16'd0) ? '0 : CNT_W'(w_dly - 16'd1);
  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        case (w_cmd.op)
          OP_WRITE, OP_POLL: w_state_nxt = ST_SETUP;
          OP_DELAY:          w_state_nxt = ST_DELAY;
          default:           w_state_nxt = ST_DONE;
        endcase
      end
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (pready) begin
          if (pslverr)          w_state_nxt = ST_ERROR;
          else if (w_poll_miss) w_state_nxt = w_poll_more ? ST_POLL_WAIT : ST_ERROR;
          else                  w_state_nxt = w_last ? ST_DONE : ST_FETCH;
        end
      end
      ST_POLL_WAIT: if (r_gap == '0) w_state_nxt = ST_SETUP;
      ST_DELAY:     if (r_cnt == '0) w_state_nxt = w_last ? ST_DONE : ST_FETCH;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cmd     <= '{op: OP_WRITE, addr: '0, data: '0, mask: '0};
      r_idx     <= '0;
      r_cnt     <= '0;
      r_gap     <= '0;
      r_err_idx <= '0;
    end else begin
      if (w_idle_like && start) begin
        r_idx     <= '0;
        r_cnt     <= '0;
        r_err_idx <= '0;
      end
      if (r_state == ST_FETCH) begin
        r_cmd <= w_cmd;
        if (w_cmd.op == OP_DELAY) r_cnt <= w_dly_load;
      end
      if (r_state == ST_ACCESS && pready) begin
        if (pslverr) begin
          r_err_idx <= r_idx;
        end else if (w_poll_miss) begin
          if (w_poll_more) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_gap <= GAP_LOAD;
          end else begin
            r_err_idx <= r_idx;
          end
        end else begin
          r_cnt <= '0;
          if (!w_last) r_idx <= r_idx + IDX_W'(1);
        end
      end
      if (r_state == ST_POLL_WAIT && r_gap != '0) r_gap <= r_gap - GAP_W'(1);
      if (r_state == ST_DELAY) begin
        if (r_cnt != '0)  r_cnt <= r_cnt - CNT_W'(1);
        else if (!w_last) r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  always_comb begin
    psel    = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    penable = (r_state == ST_ACCESS);
    pwrite  = psel && (r_cmd.op == OP_WRITE);
    paddr   = psel ? ADDR_W'(r_cmd.addr) : '0;
    pwdata  = psel ? DATA_W'(r_cmd.data) : '0;
    busy    = !w_idle_like;
    done    = (r_state == ST_DONE);
    error   = (r_state == ST_ERROR);
    err_idx = r_err_idx;
  end

endmodule
